// File: rtl/delivery_game_pkg.sv
// Shared state codes and sizing helper for the delivery game control unit.
// Also used by display/debug logic that decodes estado.
package delivery_game_pkg;

  typedef enum logic [3:0] {
    IDLE          = 4'd0,
    PREPARATION   = 4'd1,
    GET_VELOCITY  = 4'd2,
    WAIT_VELOCITY = 4'd3,
    DELAY         = 4'd4,
    GAME_OVER     = 4'd5,
    RESET_ULTRA   = 4'd6,
    PAUSED        = 4'd7,
    FAULT         = 4'd8
  } state_t;

  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_cycle_counter.sv
// Up-counter with sync clear, enable and terminal-count compare.
// Ports: clock, reset (async high), i_clear, i_enable -> o_done.
module game_cycle_counter #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_done = (r_count == WIDTH'(TERMINAL));

endmodule

// File: rtl/multi_sensor_game_uc.sv
// Control unit polling N ultrasonic sensors round-robin with timeout,
// retry/fault handling and pause. Ports: clock, reset, jogar, pausar,
// game_over, velocity_ready -> estado, sensor_sel, datapath controls.
module multi_sensor_game_uc
  import delivery_game_pkg::*;
#(
  parameter int N_SENSORS      = 2,
  parameter int DELAY_CYCLES   = 1000,
  parameter int TIMEOUT_CYCLES = 500,
  parameter int MAX_RETRIES    = 3,
  localparam int SEL_W         = min1_clog2(N_SENSORS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 jogar,
  input  logic                 pausar,
  input  logic                 game_over,
  input  logic [N_SENSORS-1:0] velocity_ready,
  output logic [3:0]           estado,
  output logic [SEL_W-1:0]     sensor_sel,
  output logic                 reset_out,
  output logic                 pronto,
  output logic                 count_map,
  output logic                 fault,
  output logic [N_SENSORS-1:0] get_velocity,
  output logic [N_SENSORS-1:0] reset_ultrasonico
);

  localparam int DW = min1_clog2(DELAY_CYCLES);
  localparam int TW = min1_clog2(TIMEOUT_CYCLES);
  localparam int RW = min1_clog2(MAX_RETRIES + 1);

  state_t r_state;
  state_t w_next;

  logic [SEL_W-1:0]     r_sel;
  logic [RW-1:0]        r_retry;
  logic [RW-1:0]        w_retry_inc;
  logic [N_SENSORS-1:0] w_onehot;
  logic                 w_ready;
  logic                 w_delay_done;
  logic                 w_tout_done;
  logic                 w_delay_clr;
  logic                 w_tout_clr;

  assign w_onehot    = N_SENSORS'(1) << r_sel;
  // only the selected channel's ready flag matters
  assign w_ready     = |(velocity_ready & w_onehot);
  assign w_retry_inc = r_retry + RW'(1);

  // delay count restarts on each completed delay and on resume
  assign w_delay_clr = (r_state == PREPARATION) ||
                       ((r_state == DELAY) && (w_next == GET_VELOCITY)) ||
                       ((r_state == PAUSED) && (w_next == GET_VELOCITY));
  assign w_tout_clr  = (r_state == PREPARATION) ||
                       (r_state == GET_VELOCITY);

  game_cycle_counter #(
    .WIDTH    (DW),
    .TERMINAL (DELAY_CYCLES - 1)
  ) u_delay_cnt (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_delay_clr),
    .i_enable (r_state == DELAY),
    .o_done   (w_delay_done)
  );

  game_cycle_counter #(
    .WIDTH    (TW),
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_tout_cnt (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_tout_clr),
    .i_enable (r_state == WAIT_VELOCITY),
    .o_done   (w_tout_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:
        w_next = jogar ? PREPARATION : IDLE;
      PREPARATION:
        w_next = GET_VELOCITY;
      GET_VELOCITY:
        if (game_over)   w_next = GAME_OVER;
        else if (pausar) w_next = PAUSED;
        else             w_next = WAIT_VELOCITY;
      WAIT_VELOCITY:
        if (game_over)        w_next = GAME_OVER;
        else if (pausar)      w_next = PAUSED;
        else if (w_ready)     w_next = DELAY;
        else if (w_tout_done) w_next = RESET_ULTRA;
        else                  w_next = WAIT_VELOCITY;
      DELAY:
        if (game_over)         w_next = GAME_OVER;
        else if (pausar)       w_next = PAUSED;
        else if (w_delay_done) w_next = GET_VELOCITY;
        else                   w_next = DELAY;
      RESET_ULTRA:
        w_next = (w_retry_inc == RW'(MAX_RETRIES)) ? FAULT
                                                   : GET_VELOCITY;
      PAUSED:
        if (game_over)   w_next = GAME_OVER;
        else if (pausar) w_next = GET_VELOCITY;
        else             w_next = PAUSED;
      GAME_OVER:
        w_next = jogar ? PREPARATION : GAME_OVER;
      FAULT:
        w_next = jogar ? PREPARATION : FAULT;
      default:
        w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sel   <= '0;
      r_retry <= '0;
    end else begin
      unique case (1'b1)
        (r_state == PREPARATION): begin
          r_sel   <= '0;
          r_retry <= '0;
        end
        (r_state == WAIT_VELOCITY) && (w_next == DELAY):
          r_retry <= '0;
        (r_state == RESET_ULTRA):
          r_retry <= w_retry_inc;
        (r_state == DELAY) && (w_next == GET_VELOCITY):
          r_sel <= (r_sel == SEL_W'(N_SENSORS - 1)) ? '0
                                                    : r_sel + SEL_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    estado            = r_state;
    sensor_sel        = r_sel;
    reset_out         = 1'b0;
    pronto            = 1'b0;
    count_map         = 1'b0;
    fault             = 1'b0;
    get_velocity      = '0;
    reset_ultrasonico = '0;
    case (r_state)
      IDLE: reset_out = 1'b1;
      PREPARATION: begin
        reset_out         = 1'b1;
        reset_ultrasonico = '1;
      end
      GET_VELOCITY: begin
        count_map    = 1'b1;
        get_velocity = w_onehot;
      end
      WAIT_VELOCITY: count_map = 1'b1;
      DELAY:         count_map = 1'b1;
      RESET_ULTRA:   reset_ultrasonico = w_onehot;
      GAME_OVER:     pronto = 1'b1;
      FAULT:         fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/multi_sensor_game_uc.md
MULTI_SENSOR_GAME_UC -- requirements
Module: multi_sensor_game_uc

Interface
REQ-001 SHALL have parameter N_SENSORS, default 2, number of ultrasonic channels polled round-robin (legal 1..8).
REQ-002 SHALL have parameter DELAY_CYCLES, default 1000, inter-measurement delay length in clock cycles (>=1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 500, cycles waited for velocity_ready before retry (>=1).
REQ-004 SHALL have parameter MAX_RETRIES, default 3, consecutive timeouts on one channel before fault (>=1).
REQ-005 SHALL have derived localparam SEL_W = max(1, clog2(N_SENSORS)).
REQ-006 clock  input  1  system clock, all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 jogar  input  1  start/restart request, level-sampled.
REQ-009 pausar  input  1  single-cycle pause/resume toggle pulse.
REQ-010 game_over  input  1  end-of-game flag from datapath.
REQ-011 velocity_ready  input  N_SENSORS  per-channel measurement-valid flags.
REQ-012 estado  output  4  current state code.
REQ-013 sensor_sel  output  SEL_W  index of active channel.
REQ-014 reset_out / pronto / count_map / fault  output  1 each  datapath clear, game finished, map counter enable, sensor fault.
REQ-015 get_velocity  output  N_SENSORS  one-hot measurement trigger.
REQ-016 reset_ultrasonico  output  N_SENSORS  per-channel sensor reset.

Function
REQ-017 Moore FSM; codes IDLE=0, PREPARATION=1, GET_VELOCITY=2, WAIT_VELOCITY=3, DELAY=4, GAME_OVER=5, RESET_ULTRA=6, PAUSED=7, FAULT=8; illegal codes -> IDLE next cycle.
REQ-018 IDLE: jogar -> PREPARATION, else stay; reset_out=1.
REQ-019 PREPARATION: one cycle; reset_out=1, reset_ultrasonico all ones; clears sensor_sel, delay counter, timeout counter, retry counter -> GET_VELOCITY.
REQ-020 GET_VELOCITY: one cycle; get_velocity[sensor_sel]=1, timeout counter cleared -> WAIT_VELOCITY.
REQ-021 WAIT_VELOCITY: timeout counter increments each cycle; velocity_ready[sensor_sel] -> DELAY with retry counter cleared; else counter == TIMEOUT_CYCLES-1 -> RESET_ULTRA; else stay.
REQ-022 velocity_ready bits of non-selected channels SHALL be ignored in every state.
REQ-023 RESET_ULTRA: one cycle; reset_ultrasonico[sensor_sel]=1, retry counter increments; if incremented value == MAX_RETRIES -> FAULT, else GET_VELOCITY on same channel.
REQ-024 DELAY: delay counter increments from 0; on counter == DELAY_CYCLES-1 counter clears, sensor_sel advances (N_SENSORS-1 wraps to 0) -> GET_VELOCITY.
REQ-025 Priority in GET_VELOCITY, WAIT_VELOCITY, DELAY: game_over > pausar > velocity_ready/delay end > timeout.
REQ-026 pausar in GET_VELOCITY/WAIT_VELOCITY/DELAY -> PAUSED; PAUSED freezes all counters and sensor_sel; pausar in PAUSED -> GET_VELOCITY (same channel, timeout and delay counters cleared); game_over in PAUSED -> GAME_OVER.
REQ-027 count_map=1 only in GET_VELOCITY, WAIT_VELOCITY, DELAY.
REQ-028 GAME_OVER: pronto=1; FAULT: fault=1, pronto=0; both exit on jogar -> PREPARATION.
REQ-029 pausar outside GET_VELOCITY/WAIT_VELOCITY/DELAY/PAUSED SHALL be ignored.
REQ-030 All outputs not named active for a state SHALL be 0; estado equals current state code.

Reset
REQ-031 reset SHALL force IDLE at any time, mid-operation included; counters, sensor_sel 0; reset_out=1, all other outputs 0 until IDLE exits.

Structure
REQ-032 State codes SHALL live in shared package delivery_game_pkg for reuse by display/debug logic.
REQ-033 One sub-module, game_cycle_counter (clear, enable, terminal-count compare, parametrised width), instantiated for delay and timeout counters; FSM and retry/select logic in top.

Verification (N_SENSORS=3, DELAY_CYCLES=4, TIMEOUT_CYCLES=5, MAX_RETRIES=2)
REQ-034 reset, jogar=1 one cycle -> estado 0,1,2; get_velocity=3'b001; sensor_sel=0.
REQ-035 velocity_ready=3'b001 in WAIT -> DELAY for exactly 4 cycles, then GET_VELOCITY with sensor_sel=1, get_velocity=3'b010; after channel 2, sel wraps to 0.
REQ-036 no ready on channel 1 -> RESET_ULTRA after 5 WAIT cycles, reset_ultrasonico=3'b010; second timeout -> FAULT, fault=1; jogar -> PREPARATION.
REQ-037 velocity_ready=3'b110 while sel=0 -> stays WAIT; game_over with ready same cycle -> GAME_OVER, pronto=1.
REQ-038 pausar at DELAY cycle 2 -> PAUSED, count_map=0, counters held; pausar -> GET_VELOCITY, same sensor_sel; reset asserted in DELAY -> estado 0 immediately.
